// File: rtl/moore_trace_decoder_pkg.sv
// Shared encodings for the 4-state Moore sequence FSM and its trace decoder.
package moore_trace_decoder_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    typedef enum logic {
        LOCK   = 1'b0,
        RELOCK = 1'b1
    } mode_t;

endpackage

// File: rtl/moore_trace_step.sv
// Combinational transition decoder: recovers x_in from a (prev, next) state pair.
module moore_trace_step
    import moore_trace_decoder_pkg::*;
(
    input  state_t prev,
    input  state_t state_in,
    output logic   legal,
    output logic   rec_bit
);

    always_comb begin
        legal   = 1'b1;
        rec_bit = 1'b0;
        case (prev)
            S0: begin
                if (state_in == S0)      rec_bit = 1'b1;
                else if (state_in != S1) legal   = 1'b0;
            end
            S1: begin
                if (state_in == S2)      rec_bit = 1'b1;
                else if (state_in != S3) legal   = 1'b0;
            end
            S2: begin
                if (state_in == S2)      rec_bit = 1'b1;
                else if (state_in != S3) legal   = 1'b0;
            end
            default: begin
                if (state_in == S3)      rec_bit = 1'b1;
                else if (state_in != S0) legal   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/moore_trace_decoder.sv
// Passive monitor: rebuilds the FSM input bit stream from its state bus,
// packs it into words and counts illegal transitions.
module moore_trace_decoder
    import moore_trace_decoder_pkg::*;
#(
    parameter int WORD_W   = 8,
    parameter int RELOCK_N = 2,
    parameter int ERR_W    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        state_in,
    input  logic              state_vld,
    input  logic              err_clr,
    output logic              bit_out,
    output logic              bit_vld,
    output logic [WORD_W-1:0] word_out,
    output logic              word_vld,
    output logic              illegal,
    output logic              err_flag,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              locked
);

    localparam int CNT_W  = $clog2(WORD_W);
    localparam int RCNT_W = 3;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t              prev_p1;
    mode_t               mode_p1;
    logic [RCNT_W-1:0]   relock_cnt_p1;
    logic [CNT_W-1:0]    bit_cnt_p1;
    logic [WORD_W-1:0]   shift_p1;

    logic                step_legal;
    logic                step_bit;
    logic [WORD_W-1:0]   shifted;

    moore_trace_step u_step (
        .prev     (prev_p1),
        .state_in (state_t'(state_in)),
        .legal    (step_legal),
        .rec_bit  (step_bit)
    );

    assign shifted = {shift_p1[WORD_W-2:0], step_bit};

    // Sample stage: one valid state_in per cycle, results registered one edge later
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_p1       <= S0;
            mode_p1       <= LOCK;
            relock_cnt_p1 <= '0;
            bit_cnt_p1    <= '0;
            shift_p1      <= '0;
            bit_out       <= 1'b0;
            bit_vld       <= 1'b0;
            word_out      <= '0;
            word_vld      <= 1'b0;
            illegal       <= 1'b0;
            err_flag      <= 1'b0;
            err_cnt       <= '0;
            locked        <= 1'b1;
        end else begin
            bit_vld  <= 1'b0;
            word_vld <= 1'b0;
            illegal  <= 1'b0;
            if (state_vld) begin
                prev_p1 <= state_t'(state_in);
                if (step_legal) begin
                    if (mode_p1 == LOCK) begin
                        bit_out  <= step_bit;
                        bit_vld  <= 1'b1;
                        shift_p1 <= shifted;
                        if (bit_cnt_p1 == CNT_W'(WORD_W - 1)) begin
                            word_out   <= shifted;
                            word_vld   <= 1'b1;
                            bit_cnt_p1 <= '0;
                        end else begin
                            bit_cnt_p1 <= bit_cnt_p1 + 1'b1;
                        end
                    end else if (relock_cnt_p1 == RCNT_W'(RELOCK_N - 1)) begin
                        mode_p1       <= LOCK;
                        locked        <= 1'b1;
                        relock_cnt_p1 <= '0;
                    end else begin
                        relock_cnt_p1 <= relock_cnt_p1 + 1'b1;
                    end
                end else begin
                    // Partial word is dropped; a fresh word starts after relock
                    illegal       <= 1'b1;
                    err_flag      <= 1'b1;
                    err_cnt       <= sat_inc(err_cnt);
                    bit_cnt_p1    <= '0;
                    shift_p1      <= '0;
                    relock_cnt_p1 <= '0;
                    mode_p1       <= RELOCK;
                    locked        <= 1'b0;
                end
            end
            if (err_clr) begin
                err_cnt  <= '0;
                err_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_moore_trace_decoder.sv
// Scoreboard bench for moore_trace_decoder: a reference model pushes expected
// outputs per driven cycle, a monitor pops and compares them after each edge.
module tb_moore_trace_decoder;

    localparam int WORD_W   = 8;
    localparam int RELOCK_N = 2;
    localparam int ERR_W    = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        state_in = 2'b00;
    logic              state_vld = 1'b0;
    logic              err_clr = 1'b0;
    logic              bit_out;
    logic              bit_vld;
    logic [WORD_W-1:0] word_out;
    logic              word_vld;
    logic              illegal;
    logic              err_flag;
    logic [ERR_W-1:0]  err_cnt;
    logic              locked;

    moore_trace_decoder #(.WORD_W(WORD_W), .RELOCK_N(RELOCK_N), .ERR_W(ERR_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .state_in  (state_in),
        .state_vld (state_vld),
        .err_clr   (err_clr),
        .bit_out   (bit_out),
        .bit_vld   (bit_vld),
        .word_out  (word_out),
        .word_vld  (word_vld),
        .illegal   (illegal),
        .err_flag  (err_flag),
        .err_cnt   (err_cnt),
        .locked    (locked)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic              bit_vld;
        logic              bit_out;
        logic              word_vld;
        logic [WORD_W-1:0] word_out;
        logic              illegal;
        logic              err_flag;
        logic [ERR_W-1:0]  err_cnt;
        logic              locked;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int word_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, req);
        end
    endtask

    // Reference model state
    logic [1:0]        m_prev;
    logic              m_locked;
    int                m_rcnt;
    int                m_bcnt;
    logic [WORD_W-1:0] m_sr;
    logic [WORD_W-1:0] m_word;
    logic              m_bit;
    logic              m_flag;
    logic [ERR_W-1:0]  m_err;

    // Successor of each state for x_in = 0 and x_in = 1
    logic [1:0] nxt0 [4] = '{2'd1, 2'd3, 2'd3, 2'd0};
    logic [1:0] nxt1 [4] = '{2'd0, 2'd2, 2'd2, 2'd3};

    task automatic model_reset();
        m_prev = 2'd0; m_locked = 1'b1; m_rcnt = 0; m_bcnt = 0;
        m_sr = '0; m_word = '0; m_bit = 1'b0; m_flag = 1'b0; m_err = '0;
    endtask

    task automatic model_step(input logic vld, input logic [1:0] s, input logic clr);
        exp_t e;
        logic is_legal, b;
        e.bit_vld = 1'b0; e.word_vld = 1'b0; e.illegal = 1'b0;
        if (vld) begin
            is_legal = (s == nxt0[m_prev]) || (s == nxt1[m_prev]);
            b = (s == nxt1[m_prev]);
            if (!is_legal) begin
                e.illegal = 1'b1;
                m_flag = 1'b1;
                if (m_err != {ERR_W{1'b1}}) m_err = m_err + 1'b1;
                m_bcnt = 0; m_rcnt = 0; m_locked = 1'b0;
            end else if (m_locked) begin
                e.bit_vld = 1'b1;
                m_bit = b;
                m_sr = {m_sr[WORD_W-2:0], b};
                m_bcnt++;
                if (m_bcnt == WORD_W) begin
                    m_word = m_sr; e.word_vld = 1'b1; m_bcnt = 0;
                end
            end else begin
                m_rcnt++;
                if (m_rcnt == RELOCK_N) begin m_locked = 1'b1; m_rcnt = 0; end
            end
            m_prev = s;
        end
        if (clr) begin m_err = '0; m_flag = 1'b0; end
        e.bit_out = m_bit; e.word_out = m_word; e.err_flag = m_flag;
        e.err_cnt = m_err; e.locked = m_locked;
        exp_q.push_back(e);
    endtask

    always @(posedge clock) begin
        #1;
        if (word_vld) word_pulses++;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("bit_vld", bit_vld, e.bit_vld);
            if (e.bit_vld) chk("bit_out", bit_out, e.bit_out);
            chk("word_vld", word_vld, e.word_vld);
            chk("word_out", word_out, e.word_out);
            chk("illegal", illegal, e.illegal);
            chk("err_flag", err_flag, e.err_flag);
            chk("err_cnt", err_cnt, e.err_cnt);
            chk("locked", locked, e.locked);
        end
    end

    task automatic step(input logic vld, input logic [1:0] s, input logic clr = 1'b0);
        @(negedge clock);
        state_vld = vld; state_in = s; err_clr = clr;
        model_step(vld, s, clr);
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; state_vld = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    logic [1:0] seq1 [8] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        chk("rst_locked", locked, 1'b1);
        chk("rst_word", word_out, 8'h00);
        chk("rst_err", err_cnt, 4'd0);
        reset = 1'b0;

        // 1: basic sequence
        for (int i = 0; i < 8; i++) begin
            step(1'b1, seq1[i]);
            chk("s1_locked", locked, 1'b1);
        end
        chk("s1_word_vld", word_vld, 1'b1);
        chk("s1_word", word_out, 8'h6A);
        chk("s1_err", err_cnt, 4'd0);

        // 2: illegal then relock
        do_reset();
        step(1'b1, 2'd2);
        chk("s2_illegal", illegal, 1'b1);
        chk("s2_err", err_cnt, 4'd1);
        chk("s2_locked", locked, 1'b0);
        chk("s2_bitvld", bit_vld, 1'b0);
        step(1'b1, 2'd3);
        chk("s2_nobit1", bit_vld, 1'b0);
        step(1'b1, 2'd0);
        chk("s2_nobit2", bit_vld, 1'b0);
        chk("s2_relocked", locked, 1'b1);
        step(1'b1, 2'd1);
        chk("s2_bit_vld", bit_vld, 1'b1);
        chk("s2_bit", bit_out, 1'b0);

        // 3: partial word discarded by an illegal transition
        do_reset();
        word_pulses = 0;
        step(1'b1, 2'd1); step(1'b1, 2'd2); step(1'b1, 2'd3);
        step(1'b1, 2'd0); step(1'b1, 2'd1);
        step(1'b1, 2'd0);
        step(1'b1, 2'd0); step(1'b1, 2'd0);
        for (int i = 0; i < 8; i++) step(1'b1, seq1[i]);
        chk("s3_pulses", word_pulses, 1);
        chk("s3_word", word_out, 8'h6A);

        // 4: valid gaps
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, seq1[i]);
            repeat ($urandom_range(1, 3)) begin
                step(1'b0, 2'($urandom_range(0, 3)));
                chk("s4_gap_pulse", {bit_vld, word_vld, illegal}, 3'b000);
            end
        end
        chk("s4_word", word_out, 8'h6A);

        // 5: saturation and clear priority
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, (i % 2 == 0) ? 2'd2 : 2'd0);
        chk("s5_sat", err_cnt, 4'd15);
        chk("s5_flag", err_flag, 1'b1);
        step(1'b1, 2'd0, 1'b1);
        chk("s5_clr_illegal", illegal, 1'b1);
        chk("s5_clr_cnt", err_cnt, 4'd0);
        chk("s5_clr_flag", err_flag, 1'b0);

        // 6: asynchronous reset mid-word
        do_reset();
        step(1'b1, 2'd1); step(1'b1, 2'd2); step(1'b1, 2'd2);
        step(1'b1, 2'd1);
        #1;
        reset = 1'b1;
        state_vld = 1'b0;
        model_reset();
        #1;
        chk("s6_async_illegal", illegal, 1'b0);
        chk("s6_async_err", err_cnt, 4'd0);
        chk("s6_async_flag", err_flag, 1'b0);
        chk("s6_async_locked", locked, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, seq1[i]);
        chk("s6_word", word_out, 8'h6A);

        repeat (2) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
